// File: rtl/wb_div_arbiter.sv
// Writeback arbiter: merges ALU and DIV result streams onto one RF write port.
// Optional WB_DIV_BYPASS_EN: DIV result skips the skid FIFO when nothing else is pending.
module wb_div_arbiter #(
  parameter int DIV_FIFO_DEPTH = 4,
  localparam int CNT_W = $clog2(DIV_FIFO_DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_do_branch,
  input  logic        ix_div_valid,
  output logic        div_stall,
  input  logic        alu_valid,
  input  logic [36:0] alu_wb_inf,
  input  logic        div_valid,
  input  logic [36:0] div_wb_inf,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        div_retire,
  output logic        err_overflow
);
  localparam int PTR_W = $clog2(DIV_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DIV_FIFO_DEPTH);

  logic [36:0]      mem_q [DIV_FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, credits_q, credits_d;
  logic             rf_we_q, rf_we_d, div_retire_q, div_retire_d;
  logic             err_overflow_q, err_overflow_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [31:0]      rf_wdata_q, rf_wdata_d;

  logic        fifo_empty, fifo_full, bypass, push, pop, sel_valid, take, ret;
  logic [36:0] sel;

  assign div_stall = (credits_q == DEPTH_C);

  always_comb begin
    fifo_empty = (cnt_q == '0);
    fifo_full  = (cnt_q == DEPTH_C);
`ifdef WB_DIV_BYPASS_EN
    bypass = fifo_empty && !alu_valid && div_valid;
`else
    bypass = 1'b0;
`endif
    pop  = !alu_valid && !fifo_empty;
    // Push-at-full is fine when the head leaves in the same cycle.
    push = div_valid && !bypass && (!fifo_full || pop);

    sel_valid = alu_valid || pop || bypass;
    if (alu_valid)  sel = alu_wb_inf;
    else if (pop)   sel = mem_q[rptr_q];
    else            sel = div_wb_inf;

    rf_we_d      = sel_valid && (sel[36:32] != 5'd0);
    rf_waddr_d   = sel_valid ? sel[36:32] : rf_waddr_q;
    rf_wdata_d   = sel_valid ? sel[31:0]  : rf_wdata_q;
    div_retire_d = pop || bypass;
    err_overflow_d = err_overflow_q || (div_valid && !bypass && fifo_full && !pop);

    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push) cnt_d = cnt_q - CNT_W'(1);

    take = ix_div_valid && !wb_do_branch && !div_stall;
    ret  = pop || bypass;
    credits_d = credits_q;
    // A stray retire with no credit outstanding must not wrap the counter.
    if (take && !ret)                           credits_d = credits_q + CNT_W'(1);
    else if (ret && !take && credits_q != '0)   credits_d = credits_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q         <= '0;
      rptr_q         <= '0;
      cnt_q          <= '0;
      credits_q      <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      div_retire_q   <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      wptr_q         <= wptr_d;
      rptr_q         <= rptr_d;
      cnt_q          <= cnt_d;
      credits_q      <= credits_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      div_retire_q   <= div_retire_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= div_wb_inf;
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign div_retire   = div_retire_q;
  assign err_overflow = err_overflow_q;
endmodule

// File: tb/tb_wb_div_arbiter.sv
// Scoreboard bench for wb_div_arbiter; expected writes queued at drive time.
module tb_wb_div_arbiter;
`ifdef WB_DIV_BYPASS_EN
  localparam int DIV_LAT = 1;
`else
  localparam int DIV_LAT = 2;
`endif

  logic        clk = 0, rst = 0;
  logic        wb_do_branch = 0, ix_div_valid = 0;
  logic        alu_valid = 0, div_valid = 0;
  logic [36:0] alu_wb_inf = '0, div_wb_inf = '0;
  logic        div_stall, rf_we, div_retire, err_overflow;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0, errors = 0;
  logic [36:0] sb[$];

  wb_div_arbiter dut (
    .clk(clk), .rst(rst), .wb_do_branch(wb_do_branch), .ix_div_valid(ix_div_valid),
    .div_stall(div_stall), .alu_valid(alu_valid), .alu_wb_inf(alu_wb_inf),
    .div_valid(div_valid), .div_wb_inf(div_wb_inf), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .div_retire(div_retire), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  // Every RF write must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && rf_we) begin
      logic [36:0] exp_e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write got rd=%0d data=%h, none expected", rf_waddr, rf_wdata);
      end else begin
        exp_e = sb.pop_front();
        if ({rf_waddr, rf_wdata} !== exp_e) begin
          errors++;
          $display("FAIL sb_write got rd=%0d data=%h exp rd=%0d data=%h",
                   rf_waddr, rf_wdata, exp_e[36:32], exp_e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_retire(output int n);
    n = 0;
    do begin
      tick(); n++;
      div_valid = 0;
    end while (!div_retire && n < 8);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, div_retire, err_overflow, div_stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b a=%0d d=%h ret=%b ovf=%b stall=%b exp all 0",
               rf_we, rf_waddr, rf_wdata, div_retire, err_overflow, div_stall);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_lone_div();
    int n;
    ix_div_valid = 1; tick(); ix_div_valid = 0;
    div_valid = 1; div_wb_inf = {5'd5, 32'h7}; sb.push_back({5'd5, 32'h7});
    wait_retire(n);
    checks++;
    if (n != DIV_LAT) begin errors++; $display("FAIL lone_latency got %0d exp %0d", n, DIV_LAT); end
    checks++;
    if (!(rf_we === 1'b1 && rf_waddr === 5'd5 && rf_wdata === 32'h7)) begin
      errors++; $display("FAIL lone_write got we=%b a=%0d d=%h exp 1/5/7", rf_we, rf_waddr, rf_wdata);
    end
    tick();
    checks++;
    if (div_retire !== 1'b0 || dut.credits_q !== '0) begin
      errors++; $display("FAIL lone_retire_once got ret=%b credits=%0d exp 0/0", div_retire, dut.credits_q);
    end
  endtask

  task automatic test_collision();
    ix_div_valid = 1; tick(); ix_div_valid = 0;
    alu_valid = 1; alu_wb_inf = {5'd3, 32'hAAAA_0000};
    div_valid = 1; div_wb_inf = {5'd4, 32'h1234};
    sb.push_back({5'd3, 32'hAAAA_0000}); sb.push_back({5'd4, 32'h1234});
    tick(); alu_valid = 0; div_valid = 0;
    checks++;
    if (!(rf_we === 1'b1 && rf_waddr === 5'd3 && div_retire === 1'b0)) begin
      errors++; $display("FAIL collision_alu got we=%b a=%0d ret=%b exp 1/3/0", rf_we, rf_waddr, div_retire);
    end
    tick();
    checks++;
    if (!(rf_we === 1'b1 && rf_waddr === 5'd4 && rf_wdata === 32'h1234 && div_retire === 1'b1)) begin
      errors++; $display("FAIL collision_div got we=%b a=%0d d=%h ret=%b exp 1/4/1234/1",
                         rf_we, rf_waddr, rf_wdata, div_retire);
    end
    tick();
  endtask

  task automatic test_credit_exhaustion();
    int n;
    ix_div_valid = 1;
    repeat (3) tick();
    checks++;
    if (div_stall !== 1'b0) begin errors++; $display("FAIL credit_3 stall got %b exp 0", div_stall); end
    tick();
    checks++;
    if (div_stall !== 1'b1) begin errors++; $display("FAIL credit_4 stall got %b exp 1", div_stall); end
    tick(); ix_div_valid = 0;
    checks++;
    if (div_stall !== 1'b1 || dut.credits_q !== 3'd4) begin
      errors++; $display("FAIL credit_5th got stall=%b credits=%0d exp 1/4", div_stall, dut.credits_q);
    end
    div_valid = 1; div_wb_inf = {5'd7, 32'h77}; sb.push_back({5'd7, 32'h77});
    wait_retire(n);
    checks++;
    if (div_retire !== 1'b1 || div_stall !== 1'b0) begin
      errors++; $display("FAIL credit_release got ret=%b stall=%b exp 1/0", div_retire, div_stall);
    end
  endtask

  task automatic test_squash();
    ix_div_valid = 1; wb_do_branch = 1; tick();
    ix_div_valid = 0; wb_do_branch = 0;
    checks++;
    if (div_stall !== 1'b0 || dut.credits_q !== 3'd3) begin
      errors++; $display("FAIL squash got stall=%b credits=%0d exp 0/3", div_stall, dut.credits_q);
    end
    ix_div_valid = 1; tick(); ix_div_valid = 0;
    checks++;
    if (div_stall !== 1'b1) begin errors++; $display("FAIL squash_refill stall got %b exp 1", div_stall); end
  endtask

  task automatic test_alu_saturation();
    logic [36:0] divq[$];
    int n;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1; alu_wb_inf = {5'(10 + c), 32'hA0 + 32'(c)};
      sb.push_back(alu_wb_inf);
      div_valid = (c >= 1 && c <= 3);
      div_wb_inf = {5'(20 + c), 32'h100 + 32'(c)};
      if (div_valid) divq.push_back(div_wb_inf);
      tick();
    end
    alu_valid = 0; div_valid = 0;
    foreach (divq[i]) sb.push_back(divq[i]);
    checks++;
    if (err_overflow !== 1'b0 || dut.cnt_q !== 3'd3) begin
      errors++; $display("FAIL sat_fifo got ovf=%b cnt=%0d exp 0/3", err_overflow, dut.cnt_q);
    end
    n = 0;
    repeat (3) begin tick(); if (rf_we === 1'b1) n++; end
    checks++;
    if (n != 3 || dut.credits_q !== 3'd1) begin
      errors++; $display("FAIL sat_drain got writes=%0d credits=%0d exp 3/1", n, dut.credits_q);
    end
  endtask

  task automatic test_x0();
    int n;
    div_valid = 1; div_wb_inf = {5'd0, 32'hDEAD};
    wait_retire(n);
    checks++;
    if (div_retire !== 1'b1 || rf_we !== 1'b0) begin
      errors++; $display("FAIL x0_write got ret=%b we=%b exp 1/0", div_retire, rf_we);
    end
    tick();
    checks++;
    if (dut.credits_q !== '0 || div_stall !== 1'b0) begin
      errors++; $display("FAIL x0_credit got credits=%0d stall=%b exp 0/0", dut.credits_q, div_stall);
    end
  endtask

  task automatic test_reset_mid();
    ix_div_valid = 1; repeat (2) tick(); ix_div_valid = 0;
    for (int c = 0; c < 2; c++) begin
      alu_valid = 1; alu_wb_inf = {5'(1 + c), 32'h5000 + 32'(c)}; sb.push_back(alu_wb_inf);
      div_valid = 1; div_wb_inf = {5'(8 + c), 32'h9000 + 32'(c)};
      tick();
    end
    alu_valid = 0; div_valid = 0;
    checks++;
    if (dut.cnt_q !== 3'd2) begin errors++; $display("FAIL rstmid_queued got %0d exp 2", dut.cnt_q); end
    @(negedge clk); #1 rst = 1; #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, div_retire, div_stall} !== '0 || dut.cnt_q !== '0 || dut.credits_q !== '0) begin
      errors++; $display("FAIL rstmid_async got we=%b a=%0d d=%h ret=%b stall=%b cnt=%0d cr=%0d exp 0",
                         rf_we, rf_waddr, rf_wdata, div_retire, div_stall, dut.cnt_q, dut.credits_q);
    end
    tick(); rst = 0;
    repeat (4) tick();
    checks++;
    if (div_retire !== 1'b0 || sb.size() != 0) begin
      errors++; $display("FAIL rstmid_after got ret=%b sb_left=%0d exp 0/0", div_retire, sb.size());
    end
  endtask

  initial begin
    fork
      begin #200000; $display("FAIL timeout"); $fatal(1); end
    join_none
    test_reset();
    test_lone_div();
    test_collision();
    test_credit_exhaustion();
    test_squash();
    test_alu_saturation();
    test_x0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
